pe_matmul_sequencer: RTL
========================

Name: pe_matmul_sequencer

Overview:
- Initiator side of the processing-element interface: drives the address, active and vec_fin strobes that a memory-attached multiply-accumulate PE consumes.
- Walks a row-major matrix product C[M×N] = A[M×K] × B[K×N] held in the shared RAM.
- Issues one operand pair per accepted step and asserts vec_fin on the last pair of each dot product, so the PE writes C[i][j] and clears its accumulator.
- Sits between the top-level job control (start/done) and one PE instance.

Parameters:
ADDR_W, 32, width of every RAM word address.
DIM_W, 16, width of the M/K/N dimension inputs.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
start  in  1  job request; sampled only in IDLE.
a_base  in  ADDR_W  word address of A[0][0].
b_base  in  ADDR_W  word address of B[0][0].
c_base  in  ADDR_W  word address of C[0][0].
m_dim  in  DIM_W  rows of A and C.
k_dim  in  DIM_W  inner dimension.
n_dim  in  DIM_W  columns of B and C.
step_fin  in  1  PE accepted the current step; advance only on active && step_fin.
active  out  1  current operand addresses are valid.
vec_fin  out  1  current step is the last step (k = K-1) of C[i][j].
left_addr  out  ADDR_W  A[i][k] address = a_base + i*K + k.
right_addr  out  ADDR_W  B[k][j] address = b_base + k*N + j.
result_addr  out  ADDR_W  C[i][j] address = c_base + i*N + j; valid whenever active.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse at job completion.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high, and overrides everything.
- Registered outputs: all outputs are registered.
- Reset state: active, vec_fin, busy and done = 0; all addresses = 0; state = IDLE.
- IDLE state:
  - On start = 1, latch the bases and dimensions.
  - If any dimension is 0, go to DONE; no step is issued.
  - Otherwise go to RUN with i = j = k = 0 and addresses preloaded. active rises the cycle after start is sampled (latency 1).
- RUN state: active = 1 throughout. A step is accepted on any cycle with step_fin = 1. With step_fin = 0, hold every output unchanged.
- Accepted step, k < K-1: k++, left_addr += 1, right_addr += N.
- Accepted step, k = K-1 (vec_fin was high):
  - k = 0 and result_addr += 1.
  - If j < N-1: j++; left_addr = row base (a_base + i*K); right_addr = b_base + j + 1.
  - Else: j = 0 and i++; row base += K; left_addr = new row base; right_addr = b_base.
  - If i = M-1 and j = N-1: go to DONE instead; active and vec_fin drop on that edge.
- vec_fin = active && (k = K-1). When K = 1, vec_fin is high on every step.
- DONE state: done = 1 for exactly one cycle, then IDLE. busy is low in DONE.
- Arithmetic: addresses are generated incrementally (adds only, no multipliers). Arithmetic is modulo 2^ADDR_W; wrap-around is not flagged. Counters are DIM_W wide.
- Throughput: with step_fin tied high, the job takes M*N*K active cycles, plus 1 cycle start latency and 1 cycle of DONE.
- start while RUN or DONE: ignored, not queued.
- Input changes mid-job: changing the base or dimension inputs has no effect; latched values are used.
- rst mid-job: immediate return to IDLE, all outputs zero, no done pulse. The PE accumulator is not the sequencer's responsibility.

Test Plan:
1. Basic 2×2×2 job, step_fin = 1: M=K=N=2, a_base=0, b_base=16, c_base=32.
   - (left, right, result, vec_fin) per cycle = (0,16,32,0) (1,18,32,1) (0,17,33,0) (1,19,33,1) (2,16,34,0) (3,18,34,1) (2,17,35,0) (3,19,35,1).
   - done pulses on the following cycle; 8 active cycles in total.
2. K=1 outer product, M=2, N=3, bases 0/8/20: vec_fin high on all 6 steps; left = 0,0,0,1,1,1; right = 8,9,10,8,9,10; result = 20..25.
3. Stall: run case 1 with step_fin low on alternate cycles. Each address tuple is held 2 cycles; the sequence is identical to case 1; done comes after 16 active cycles.
4. Zero dimension: m_dim=3, k_dim=0, n_dim=4, start pulse. active never rises; done pulses 1 cycle after start; busy stays 0.
5. Reset mid-job: case 1 with rst asserted after 3 accepted steps. The next cycle shows all outputs 0 and IDLE, with no done. A fresh start then replays the full case-1 sequence from (0,16,32,0).
6. start ignored when busy: assert start again mid-RUN with different bases. The sequence is unchanged and exactly one done pulse is produced.

Source files
------------

// File: rtl/pe_matmul_sequencer_if.sv
// Processing-element operand interface.
// The sequencer (master) drives the operand/result addresses, the active
// strobe and vec_fin. The PE (slave) returns step_fin to accept the current step.
//   active      : operand addresses are valid this cycle
//   vec_fin     : current step is the last one of a dot product
//   left_addr   : A operand word address
//   right_addr  : B operand word address
//   result_addr : C destination word address
//   step_fin    : PE accepted the current step
interface pe_matmul_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic              active;
   logic              vec_fin;
   logic [ADDR_W-1:0] left_addr;
   logic [ADDR_W-1:0] right_addr;
   logic [ADDR_W-1:0] result_addr;
   logic              step_fin;

   modport master (
      output active, vec_fin, left_addr, right_addr, result_addr,
      input  step_fin
   );

   modport slave (
      input  active, vec_fin, left_addr, right_addr, result_addr,
      output step_fin
   );
endinterface

// File: rtl/pe_matmul_sequencer.sv
// Matrix-product address sequencer for one memory-attached MAC PE.
// Walks C[M x N] = A[M x K] * B[K x N] (row-major, word addressed) and
// issues one operand pair per accepted step. vec_fin marks the last pair of
// each dot product so the PE writes C[i][j] and clears its accumulator.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : job request, only honoured in IDLE
//   a_base/b_base/c_base  : word addresses of A[0][0], B[0][0], C[0][0]
//   m_dim/k_dim/n_dim     : matrix dimensions (any zero -> empty job)
//   pe                    : PE operand interface (master side)
//   busy                  : high while stepping through the job
//   done                  : one-cycle pulse at job completion
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold their last values
// RUN   | issuing operand steps, advancing on step_fin
// DONE  | single-cycle completion pulse, then back to IDLE
module pe_matmul_sequencer #(
   parameter int ADDR_W = 32,
   parameter int DIM_W  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [ADDR_W-1:0]            a_base,
   input  logic [ADDR_W-1:0]            b_base,
   input  logic [ADDR_W-1:0]            c_base,
   input  logic [DIM_W-1:0]             m_dim,
   input  logic [DIM_W-1:0]             k_dim,
   input  logic [DIM_W-1:0]             n_dim,
   pe_matmul_sequencer_if.master        pe,
   output logic                         busy,
   output logic                         done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_n;

   logic [DIM_W-1:0]  m_q, m_n;
   logic [DIM_W-1:0]  k_dim_q, k_dim_n;
   logic [DIM_W-1:0]  n_q, n_n;
   logic [ADDR_W-1:0] b_base_q, b_base_n;

   logic [DIM_W-1:0]  i_q, i_n;
   logic [DIM_W-1:0]  j_q, j_n;
   logic [DIM_W-1:0]  k_q, k_n;

   // row_q tracks a_base + i*K, col_q tracks b_base + j; both are kept so
   // that wrapping to a new dot product needs only adds.
   logic [ADDR_W-1:0] row_q, row_n;
   logic [ADDR_W-1:0] col_q, col_n;

   logic [ADDR_W-1:0] left_q, left_n;
   logic [ADDR_W-1:0] right_q, right_n;
   logic [ADDR_W-1:0] result_q, result_n;
   logic              active_q, active_n;
   logic              vec_fin_q, vec_fin_n;
   logic              busy_q, busy_n;
   logic              done_q, done_n;

   logic              accept;
   logic              last_k, last_j, last_i;
   logic [DIM_W-1:0]  k_last;
   logic [ADDR_W-1:0] k_ext, n_ext;

   assign k_last = k_dim_q - DIM_W'(1);
   assign last_k = (k_q == k_last);
   assign last_j = (j_q == n_q - DIM_W'(1));
   assign last_i = (i_q == m_q - DIM_W'(1));
   assign k_ext  = ADDR_W'(k_dim_q);
   assign n_ext  = ADDR_W'(n_q);
   assign accept = active_q && pe.step_fin;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         m_q       <= '0;
         k_dim_q   <= '0;
         n_q       <= '0;
         b_base_q  <= '0;
         i_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         row_q     <= '0;
         col_q     <= '0;
         left_q    <= '0;
         right_q   <= '0;
         result_q  <= '0;
         active_q  <= 1'b0;
         vec_fin_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_n;
         m_q       <= m_n;
         k_dim_q   <= k_dim_n;
         n_q       <= n_n;
         b_base_q  <= b_base_n;
         i_q       <= i_n;
         j_q       <= j_n;
         k_q       <= k_n;
         row_q     <= row_n;
         col_q     <= col_n;
         left_q    <= left_n;
         right_q   <= right_n;
         result_q  <= result_n;
         active_q  <= active_n;
         vec_fin_q <= vec_fin_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      m_n       = m_q;
      k_dim_n   = k_dim_q;
      n_n       = n_q;
      b_base_n  = b_base_q;
      i_n       = i_q;
      j_n       = j_q;
      k_n       = k_q;
      row_n     = row_q;
      col_n     = col_q;
      left_n    = left_q;
      right_n   = right_q;
      result_n  = result_q;
      active_n  = active_q;
      vec_fin_n = vec_fin_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_n      = m_dim;
               k_dim_n  = k_dim;
               n_n      = n_dim;
               b_base_n = b_base;
               if (m_dim == '0 || k_dim == '0 || n_dim == '0) begin
                  state_n = S_DONE;
               end else begin
                  state_n   = S_RUN;
                  i_n       = '0;
                  j_n       = '0;
                  k_n       = '0;
                  row_n     = a_base;
                  col_n     = b_base;
                  left_n    = a_base;
                  right_n   = b_base;
                  result_n  = c_base;
                  active_n  = 1'b1;
                  vec_fin_n = (k_dim == DIM_W'(1));
               end
            end
         end

         S_RUN: begin
            if (accept) begin
               if (!last_k) begin
                  k_n       = k_q + DIM_W'(1);
                  left_n    = left_q + ADDR_W'(1);
                  right_n   = right_q + n_ext;
                  vec_fin_n = (k_q + DIM_W'(1) == k_last);
               end else if (last_i && last_j) begin
                  state_n   = S_DONE;
                  active_n  = 1'b0;
                  vec_fin_n = 1'b0;
               end else begin
                  k_n       = '0;
                  result_n  = result_q + ADDR_W'(1);
                  vec_fin_n = (k_last == '0);
                  if (!last_j) begin
                     j_n     = j_q + DIM_W'(1);
                     left_n  = row_q;
                     col_n   = col_q + ADDR_W'(1);
                     right_n = col_q + ADDR_W'(1);
                  end else begin
                     j_n     = '0;
                     i_n     = i_q + DIM_W'(1);
                     row_n   = row_q + k_ext;
                     left_n  = row_q + k_ext;
                     col_n   = b_base_q;
                     right_n = b_base_q;
                  end
               end
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n   = S_IDLE;
            active_n  = 1'b0;
            vec_fin_n = 1'b0;
         end
      endcase

      busy_n = (state_n == S_RUN);
      done_n = (state_n == S_DONE);
   end

   assign pe.active      = active_q;
   assign pe.vec_fin     = vec_fin_q;
   assign pe.left_addr   = left_q;
   assign pe.right_addr  = right_q;
   assign pe.result_addr = result_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule
